// File: rtl/flash_region_loader_pkg.sv
// Shared types and memory-map constants for the boot-time flash-to-SD-RAM copier.
// Holds the region descriptor type, the FSM state encoding and the default
// region table built from the flash/SD-RAM memory map.
package flash_region_loader_pkg;

    typedef struct packed {
        logic [23:0] flash_addr;
        logic [23:0] ram_addr;
        logic [23:0] size;
    } region_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_STREAM,
        S_DRAIN,
        S_FIN
    } state_t;

    // Flash / SD-RAM memory map
    localparam logic [23:0] FLASH_NEXTOR  = 24'h100000;
    localparam logic [23:0] RAM_NEXTOR    = 24'h700000;
    localparam logic [23:0] SIZE_NEXTOR   = 24'h020000;
    localparam logic [23:0] FLASH_FM      = 24'h120000;
    localparam logic [23:0] RAM_FM        = 24'h720000;
    localparam logic [23:0] SIZE_FM       = 24'h004000;
    localparam logic [23:0] FLASH_PAC     = 24'h124000;
    localparam logic [23:0] RAM_PAC       = 24'h724000;
    localparam logic [23:0] SIZE_PAC      = 24'h004000;
    localparam logic [23:0] FLASH_MEGAROM = 24'h200000;
    localparam logic [23:0] RAM_MEGAROM   = 24'h400000;
    localparam logic [23:0] SIZE_MEGAROM  = 24'h100000;

    localparam region_t REGION_NEXTOR  = region_t'{FLASH_NEXTOR,  RAM_NEXTOR,  SIZE_NEXTOR};
    localparam region_t REGION_FM      = region_t'{FLASH_FM,      RAM_FM,      SIZE_FM};
    localparam region_t REGION_PAC     = region_t'{FLASH_PAC,     RAM_PAC,     SIZE_PAC};
    localparam region_t REGION_MEGAROM = region_t'{FLASH_MEGAROM, RAM_MEGAROM, SIZE_MEGAROM};

    // Index 0 is loaded first.
    localparam region_t [2:0] DEFAULT_REGIONS = {REGION_PAC, REGION_FM, REGION_NEXTOR};

endpackage

// File: rtl/flash_region_loader_fifo.sv
// loader_fifo: synchronous word FIFO between the byte packer and the SD-RAM port.
// Ports: clk, reset_n (async low), push/wdata, pop/rdata (show-ahead head),
// flush (synchronous clear, wins over push/pop), full, empty.
module loader_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/flash_region_loader.sv
// flash_region_loader: walks a region table at boot, streams each region from
// the SPI flash reader, packs bytes little-endian into RAM_W-bit words and writes
// them through the SD-RAM arbiter port, reporting a 16-bit byte sum per region.
// Ports: start/abort/region_en control; fl_* flash stream (start/addr/len/abort
// out, valid/data in, ready out); ram_* write port (req held until ack);
// busy/done/aborted status; region_idx/sum/sum_valid per-region report.
module flash_region_loader
    import flash_region_loader_pkg::*;
#(
    parameter int                        NUM_REGIONS = 3,
    parameter region_t [NUM_REGIONS-1:0] REGIONS     = DEFAULT_REGIONS,
    parameter int                        RAM_W       = 16,
    parameter int                        FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_REGIONS-1:0] region_en,
    output logic                   fl_start,
    output logic [23:0]            fl_addr,
    output logic [23:0]            fl_len,
    output logic                   fl_abort,
    input  logic                   fl_valid,
    input  logic [7:0]             fl_data,
    output logic                   fl_ready,
    output logic                   ram_req,
    output logic [23:0]            ram_addr,
    output logic [RAM_W-1:0]       ram_wdata,
    output logic [RAM_W/8-1:0]     ram_be,
    input  logic                   ram_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [2:0]             region_idx,
    output logic [15:0]            sum,
    output logic                   sum_valid
);
    localparam int             BPW      = RAM_W / 8;
    localparam int             LW       = $clog2(BPW);
    localparam int             FW       = RAM_W + BPW;
    localparam logic [2:0]     LAST_IDX = 3'(NUM_REGIONS - 1);
    localparam logic [23:0]    ALIGN    = ~24'(BPW - 1);

    state_t                   state;
    logic [NUM_REGIONS-1:0]   en_q;
    logic [2:0]               idx;
    region_t                  cur;
    logic                     region_on;
    logic [23:0]              byte_cnt, wr_addr;
    logic [LW-1:0]            lane;
    logic [BPW-1:0][7:0]      pack_data, word_data;
    logic [BPW-1:0]           word_be;
    logic                     abort_act, last_byte, word_end, hs, drain_ok;
    logic                     push, pop, full, empty;
    logic [FW-1:0]            fifo_rdata;

    // Table lookup for the region under examination.
    always_comb begin
        cur       = '0;
        region_on = 1'b0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (idx == 3'(r)) begin
                cur       = REGIONS[r];
                region_on = en_q[r] && (REGIONS[r].size != 24'd0);
            end
        end
    end

    // Word as it would look with the incoming byte merged in; lanes not yet
    // written keep 8'hFF from the pack register.
    always_comb begin
        word_data       = pack_data;
        word_data[lane] = fl_data;
        for (int l = 0; l < BPW; l++) word_be[l] = (LW'(l) <= lane);
    end

    assign abort_act = abort && (state != S_IDLE);
    assign last_byte = (byte_cnt == cur.size - 24'd1);
    assign word_end  = (lane == LW'(BPW - 1)) || last_byte;
    // Only stall when the byte would complete a word that has nowhere to go.
    assign fl_ready  = (state == S_STREAM) && (!full || !word_end);
    assign hs        = fl_valid && fl_ready;
    assign push      = hs && word_end && !abort_act;
    assign pop       = !abort_act && (!ram_req || ram_ack) && !empty;
    assign drain_ok  = (state == S_DRAIN) && empty && !ram_req;
    assign sum_valid = drain_ok && !abort_act;

    loader_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   ({word_be, word_data}),
        .pop     (pop),
        .flush   (abort_act),
        .rdata   (fifo_rdata),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            en_q       <= '0;
            idx        <= '0;
            byte_cnt   <= '0;
            wr_addr    <= '0;
            lane       <= '0;
            pack_data  <= '1;
            fl_start   <= 1'b0;
            fl_addr    <= '0;
            fl_len     <= '0;
            fl_abort   <= 1'b0;
            ram_req    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_be     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            region_idx <= '0;
            sum        <= '0;
        end else begin
            fl_start <= 1'b0;
            fl_abort <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;

            // RAM side: refill on ack so a ready head follows the next cycle.
            if (abort_act) begin
                ram_req <= 1'b0;
            end else if (pop) begin
                ram_req   <= 1'b1;
                ram_wdata <= fifo_rdata[RAM_W-1:0];
                ram_be    <= fifo_rdata[FW-1:RAM_W];
                ram_addr  <= wr_addr;
                wr_addr   <= wr_addr + 24'(BPW);
            end else if (ram_ack) begin
                ram_req <= 1'b0;
            end

            if (hs && !abort_act) begin
                sum      <= sum + 16'(fl_data);
                byte_cnt <= byte_cnt + 24'd1;
                if (word_end) begin
                    lane      <= '0;
                    pack_data <= '1;
                end else begin
                    lane      <= lane + LW'(1);
                    pack_data <= word_data;
                end
            end

            case (state)
                S_IDLE: if (start) begin
                    en_q  <= region_en;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= S_SELECT;
                end
                // Last-index check is folded into the skip/exit decision so
                // running off the table costs no extra cycle.
                S_SELECT: if (region_on) begin
                    state      <= S_ISSUE;
                    fl_start   <= 1'b1;
                    fl_addr    <= cur.flash_addr;
                    fl_len     <= cur.size;
                    region_idx <= idx;
                    sum        <= '0;
                    byte_cnt   <= '0;
                    lane       <= '0;
                    pack_data  <= '1;
                    wr_addr    <= cur.ram_addr & ALIGN;
                end else if (idx == LAST_IDX) begin
                    state <= S_FIN;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    idx <= idx + 3'd1;
                end
                S_ISSUE:  state <= S_STREAM;
                S_STREAM: if (hs && last_byte) state <= S_DRAIN;
                S_DRAIN: if (drain_ok) begin
                    if (idx == LAST_IDX) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= S_SELECT;
                    end
                end
                S_FIN:    state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            if (abort_act) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                fl_start  <= 1'b0;
                fl_abort  <= 1'b1;
                aborted   <= 1'b1;
                lane      <= '0;
                pack_data <= '1;
            end
        end
    end

endmodule

// File: doc/flash_region_loader.md
# flash_region_loader

Parametrised boot copier that moves up to NUM_REGIONS flash regions (NEXTOR, FM-BIOS, PAC, MEGAROM, …) into SD-RAM at power-up. It is the executable form of the flash/SD-RAM memory maps: it walks a region table, streams bytes from the SPI flash reader, packs them into RAM_W-bit words and writes them through the SD-RAM arbiter port. It also reports a per-region byte checksum. It sits between the flash reader and the SD-RAM controller and holds the CPU-side cartridge logic off until loading is done.

## Interface
Parameters:
- NUM_REGIONS, 3 — entries in REGIONS; range 1..8.
- REGIONS, CONFIG::DEFAULT_REGIONS — array [NUM_REGIONS] of CONFIG::region_t {flash_addr, ram_addr, size} (24 bit each).
- RAM_W, 16 — SD-RAM word width; 16 or 32; BPW = RAM_W/8 bytes per word.
- FIFO_DEPTH, 8 — word FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin loading; ignored unless idle.
- abort  in  1  pulse; cancel the load in progress.
- region_en  in  NUM_REGIONS  runtime enable mask, sampled on start.
- fl_start  out  1  one-cycle pulse; begin a flash stream.
- fl_addr  out  24  flash byte address; valid with fl_start.
- fl_len  out  24  byte count; valid with fl_start.
- fl_abort  out  1  one-cycle pulse; stop the flash stream.
- fl_valid  in  1  byte available.
- fl_data  in  8  flash byte.
- fl_ready  out  1  byte accept; transfer occurs when fl_valid & fl_ready.
- ram_req  out  1  write request; held until ram_ack.
- ram_addr  out  24  byte address, BPW-aligned.
- ram_wdata  out  RAM_W  write data.
- ram_be  out  BPW  byte enables.
- ram_ack  in  1  one-cycle accept of the current request.
- busy  out  1  loading in progress.
- done  out  1  one-cycle pulse; all regions loaded.
- aborted  out  1  one-cycle pulse; load cancelled.
- region_idx  out  3  region currently being loaded.
- sum  out  16  byte sum mod 2^16 of the finished region.
- sum_valid  out  1  one-cycle pulse; sum and region_idx are valid.

## Operation
- Reset values: all outputs 0; FSM in IDLE; FIFO empty.
- FSM states: IDLE → SELECT → ISSUE → STREAM → DRAIN → SELECT … → FIN → IDLE.
  - IDLE: on start, latch region_en, set i=0, go to SELECT.
  - SELECT: takes one cycle per region examined. If i=NUM_REGIONS, go to FIN. If region i is disabled or has size 0, increment i and stay in SELECT. Otherwise go to ISSUE.
  - ISSUE: pulse fl_start with REGIONS[i].flash_addr and .size; go to STREAM.
  - STREAM: accept bytes; go to DRAIN when the byte count reaches size.
  - DRAIN: wait until the FIFO is empty and no ram_req is outstanding; then pulse sum_valid, increment i, go to SELECT.
  - FIN: pulse done; go to IDLE.
- Packing is little-endian: the first byte goes to lane 0. A lane counter wraps at BPW.
- A completed word is pushed into the FIFO with ram_be all ones.
- If size is not a multiple of BPW, the final partial word is pushed at end of stream. It carries ones only in the filled lanes; unfilled lanes hold 8'hFF.
- fl_ready = FIFO not full, or a word is not about to be pushed this cycle. A full FIFO backpressures the flash stream.
- RAM side: pop the FIFO head into the ram_req/ram_addr/ram_wdata/ram_be registers. These stay stable until ram_ack.
  - ram_addr starts at REGIONS[i].ram_addr and advances by BPW per ack.
- sum accumulates every accepted byte and clears on ISSUE.
- abort, or start while busy:
  - start while busy is ignored.
  - abort in any non-IDLE state pulses fl_abort and flushes the FIFO.
  - abort drops ram_req immediately; an outstanding request is abandoned, because the SD-RAM arbiter treats req deassertion as a cancel.
  - abort pulses aborted, returns to IDLE, and never produces done.
- Asynchronous reset mid-load returns every output to its reset value on the same edge.

## Timing
- start sampled at cycle T → busy=1 at T+1 (SELECT).
- First enabled region is index 0 → fl_start at T+2.
- Byte handshake at cycle B completes a word → FIFO push at B+1, ram_req earliest at B+2.
- ram_ack at cycle A → next word presented at A+1. Sustained throughput is one word per 2 cycles when ram_ack is immediate.
- DRAIN exit → sum_valid on the exit cycle; next fl_start ≥2 cycles later.
- Last region's DRAIN exit at D → done at D+1+(regions skipped); busy falls in the same cycle as done.
- All regions disabled → done at T+1+NUM_REGIONS, with no fl_start.

## Structure
- CONFIG package gains:
  - typedef region_t;
  - REGION_NEXTOR, REGION_FM, REGION_PAC and REGION_MEGAROM, built from the existing FLASH_/RAM_ address and size constants;
  - DEFAULT_REGIONS.
- Sub-module loader_fifo: synchronous FIFO with parameters WIDTH = RAM_W+BPW and DEPTH = FIFO_DEPTH; provides push, pop, full, empty and flush.

## Test plan
- Default table, RAM_W=16, all enabled, ram_ack immediate:
  - fl_start at 24'h100000/24'h020000, then 24'h120000/24'h004000;
  - RAM writes begin at 24'h700000 and 24'h720000;
  - 3 sum_valid pulses, then done.
- Region size 5, bytes 01..05, RAM_W=32 → writes 32'h04030201 be=4'hF, then 32'hFFFFFF05 be=4'h1 at base+4; sum=16'h000F.
- Hold ram_ack low for 40 cycles:
  - FIFO fills and fl_ready drops;
  - ram_req/addr/data stay stable throughout;
  - no byte is lost.
- region_en=3'b000, start at T → done at T+4, no fl_start, busy high for cycles T+1..T+3.
- abort mid-STREAM: fl_abort and aborted pulse, ram_req drops next cycle, no done; a new start then reloads from region 0.
- start while busy is ignored; reset_n low mid-load clears busy, ram_req and region_idx asynchronously.
